seq_multiplier: RTL and testbench

Iterative, parametrised RV M-extension multiplier with valid/ready handshakes on request and response. It is the multi-cycle successor to the single-cycle combinational multiplier.
- Retires BITS_PER_CYCLE multiplier bits per clock, trading latency for area and timing.
- Sits in the execute stage beside the ALU. The pipeline stalls on req_ready/resp_valid and can flush it with kill.

---
 rtl/seq_multiplier_pkg.sv | 26 ++
 rtl/seq_multiplier_if.sv | 24 ++
 rtl/seq_multiplier_mul_step.sv | 25 ++
 rtl/seq_multiplier.sv | 144 ++++++++++++++
 tb/tb_seq_multiplier.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/seq_multiplier_pkg.sv
// Shared encodings for the iterative RV M-extension multiplier:
// multiply-mode selects, FSM states and per-mode operand signedness.
package seq_multiplier_pkg;

    typedef enum logic [1:0] {
        MUL_LO    = 2'd0,
        MUL_HI    = 2'd1,
        MUL_HI_SU = 2'd2,
        MUL_HI_UU = 2'd3
    } mul_sel_e;

    typedef enum logic [1:0] {
        MULST_IDLE = 2'd0,
        MULST_BUSY = 2'd1,
        MULST_DONE = 2'd2
    } mul_state_e;

    function automatic logic op1_is_signed(input mul_sel_e sel);
        return sel != MUL_HI_UU;
    endfunction

    function automatic logic op2_is_signed(input mul_sel_e sel);
        return (sel == MUL_LO) || (sel == MUL_HI);
    endfunction

endpackage

// File: rtl/seq_multiplier_if.sv
// Request/response handshake bundle between the execute stage and the
// iterative multiplier.
interface seq_multiplier_if #(
    parameter int XLEN = 32
);
    logic            req_valid;
    logic            req_ready;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic [1:0]      mul_sel;
    logic            resp_valid;
    logic            resp_ready;
    logic [XLEN-1:0] result;

    modport master (
        output req_valid, op1, op2, mul_sel, resp_ready,
        input  req_ready, resp_valid, result
    );

    modport slave (
        input  req_valid, op1, op2, mul_sel, resp_ready,
        output req_ready, resp_valid, result
    );
endinterface

// File: rtl/seq_multiplier_mul_step.sv
// One iteration of the shift-and-add multiplier: adds mcand * digit, aligned
// to the digit position selected by count, into the double-width accumulator.
module seq_multiplier_mul_step #(
    parameter int XLEN           = 32,
    parameter int BITS_PER_CYCLE = 4,
    parameter int CW             = 3
) (
    input  logic [XLEN-1:0]           mcand,
    input  logic [BITS_PER_CYCLE-1:0] digit,
    input  logic [CW-1:0]             count,
    input  logic [2*XLEN-1:0]         acc,
    output logic [2*XLEN-1:0]         acc_next
);
    localparam int AW = 2 * XLEN;

    logic [AW-1:0] partial;
    logic [31:0]   shamt;

    // Both factors are widened first so the product never loses carry bits.
    always_comb begin
        partial  = AW'(mcand) * AW'(digit);
        shamt    = 32'(count) * 32'(BITS_PER_CYCLE);
        acc_next = acc + (partial << shamt);
    end
endmodule

// File: rtl/seq_multiplier.sv
// Iterative multiplier: operands are reduced to magnitudes on accept, summed
// BITS_PER_CYCLE multiplier bits per cycle, and sign-corrected on the last step.
module seq_multiplier
    import seq_multiplier_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int BITS_PER_CYCLE = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                kill,
    seq_multiplier_if.slave     bus
);
    localparam int LATENCY = XLEN / BITS_PER_CYCLE;
    localparam int CW      = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int AW      = 2 * XLEN;

    if ((XLEN % 2) != 0 || XLEN < 8 || (XLEN % BITS_PER_CYCLE) != 0) begin : g_param_check
        $error("seq_multiplier: unsupported XLEN/BITS_PER_CYCLE combination");
    end

    mul_state_e      state;
    mul_state_e      state_next;
    logic            accept;
    logic            step;
    logic            last;

    logic [CW-1:0]   count;
    logic [XLEN-1:0] mcand;
    logic [XLEN-1:0] mplier;
    logic [AW-1:0]   acc;
    logic [AW-1:0]   acc_next;
    logic [AW-1:0]   product;
    logic            neg;
    mul_sel_e        sel;
    logic [XLEN-1:0] result_q;

    mul_sel_e        req_sel;
    logic            op1_signed;
    logic            op2_signed;

    function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] v,
                                                  input logic is_signed);
        logic signed [XLEN-1:0] sv;
        sv = $signed(v);
        // The most negative value maps to 2^(XLEN-1), still representable unsigned.
        if (is_signed && sv < 0)
            return $unsigned(-sv);
        return v;
    endfunction

    function automatic logic [AW-1:0] apply_sign(input logic [AW-1:0] mag,
                                                 input logic negate);
        return negate ? (~mag + 1'b1) : mag;
    endfunction

    always_comb begin
        req_sel    = mul_sel_e'(bus.mul_sel);
        op1_signed = op1_is_signed(req_sel);
        op2_signed = op2_is_signed(req_sel);
    end

    seq_multiplier_mul_step #(
        .XLEN           (XLEN),
        .BITS_PER_CYCLE (BITS_PER_CYCLE),
        .CW             (CW)
    ) u_step (
        .mcand    (mcand),
        .digit    (mplier[BITS_PER_CYCLE-1:0]),
        .count    (count),
        .acc      (acc),
        .acc_next (acc_next)
    );

    assign product = apply_sign(acc_next, neg);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= MULST_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        step       = 1'b0;
        last       = 1'b0;
        case (state)
            MULST_IDLE: begin
                if (bus.req_valid && !kill) begin
                    accept     = 1'b1;
                    state_next = MULST_BUSY;
                end
            end
            MULST_BUSY: begin
                step = !kill;
                if (count == CW'(LATENCY - 1)) begin
                    last       = !kill;
                    state_next = MULST_DONE;
                end
            end
            MULST_DONE: begin
                if (bus.resp_ready)
                    state_next = MULST_IDLE;
            end
            default: state_next = MULST_IDLE;
        endcase
        // Flush wins over every other transition.
        if (kill)
            state_next = MULST_IDLE;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count    <= '0;
            mcand    <= '0;
            mplier   <= '0;
            acc      <= '0;
            neg      <= 1'b0;
            sel      <= MUL_LO;
            result_q <= '0;
        end else begin
            if (accept) begin
                mcand  <= magnitude(bus.op1, op1_signed);
                mplier <= magnitude(bus.op2, op2_signed);
                neg    <= (op1_signed & bus.op1[XLEN-1]) ^ (op2_signed & bus.op2[XLEN-1]);
                sel    <= req_sel;
                acc    <= '0;
                count  <= '0;
            end else if (step) begin
                acc    <= acc_next;
                mplier <= mplier >> BITS_PER_CYCLE;
                count  <= count + 1'b1;
            end
            if (last)
                result_q <= (sel == MUL_LO) ? product[XLEN-1:0] : product[AW-1:XLEN];
        end
    end

    assign bus.req_ready  = (state == MULST_IDLE);
    assign bus.resp_valid = (state == MULST_DONE);
    assign bus.result     = result_q;
endmodule

// File: tb/tb_seq_multiplier.sv
// Randomized and directed bench for seq_multiplier with a queue scoreboard
// checked by an independent response monitor.
module tb_seq_multiplier;
    localparam int XLEN    = 32;
    localparam int LATENCY = 8;

    logic clk;
    logic reset_n;
    logic kill;

    seq_multiplier_if #(.XLEN(XLEN)) bus ();

    seq_multiplier #(
        .XLEN           (XLEN),
        .BITS_PER_CYCLE (4)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .kill    (kill),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: sign/zero-extend to 64 bits and take the wrapped product.
    function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                            input logic [1:0] sel);
        logic [63:0] ea, eb, p;
        ea = (sel != 2'd3) ? {{32{a[31]}}, a} : {32'h0, a};
        eb = (sel <= 2'd1) ? {{32{b[31]}}, b} : {32'h0, b};
        p  = ea * eb;
        return (sel == 2'd0) ? p[31:0] : p[63:32];
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            4: return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    logic        held;
    logic [31:0] held_val;

    always @(negedge clk) begin
        if (reset_n && bus.resp_valid) begin
            if (!bus.resp_ready) begin
                if (held)
                    check("result_stable", bus.result, held_val);
                held     = 1'b1;
                held_val = bus.result;
            end else begin
                held = 1'b0;
                if (!kill) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_resp: got result 0x%0h with no request outstanding",
                                 bus.result);
                    end else begin
                        check("result", bus.result, exp_q.pop_front());
                    end
                end
            end
        end else begin
            held = 1'b0;
        end
    end

    // kill_mode: 0 normal, 1 kill in 3rd BUSY cycle, 2 kill in DONE, 3 async reset mid-BUSY
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] sel,
                         input logic [31:0] exp, input int ready_delay, input int kill_mode);
        int n;
        int lat;
        logic saw_ready;
        n = 0;
        while (!bus.req_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("req_ready_before_op", bus.req_ready, 1);
        bus.op1        = a;
        bus.op2        = b;
        bus.mul_sel    = sel;
        bus.req_valid  = 1'b1;
        bus.resp_ready = (ready_delay == 0) || (kill_mode == 1);
        if (kill_mode == 0)
            exp_q.push_back(exp);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        bus.mul_sel   = 2'($urandom);
        bus.op1       = $urandom;
        bus.op2       = $urandom;

        if (kill_mode == 1) begin
            repeat (2) @(posedge clk);
            #1 kill = 1'b1;
            @(posedge clk); #1;
            kill = 1'b0;
            check("kill_busy_idle", {bus.req_ready, bus.resp_valid}, 2'b10);
            repeat (12) @(posedge clk);
            #1 check("kill_busy_no_resp", bus.resp_valid, 0);
            return;
        end
        if (kill_mode == 3) begin
            repeat (3) @(posedge clk);
            #3 reset_n = 1'b0;
            #1 check("async_reset", {bus.req_ready, bus.resp_valid, bus.result},
                     {1'b1, 1'b0, 32'h0});
            #3 reset_n = 1'b1;
            return;
        end

        lat       = 0;
        saw_ready = 1'b0;
        do begin
            @(posedge clk); #1;
            lat++;
            if (!bus.resp_valid && bus.req_ready)
                saw_ready = 1'b1;
        end while (!bus.resp_valid && lat < 20);
        check("latency", lat, LATENCY);
        check("req_ready_low_busy", saw_ready, 0);

        if (kill_mode == 2) begin
            kill           = 1'b1;
            bus.resp_ready = 1'b1;
            @(posedge clk); #1;
            kill = 1'b0;
            check("kill_done_idle", {bus.req_ready, bus.resp_valid}, 2'b10);
            return;
        end

        if (ready_delay > 0) begin
            repeat (ready_delay) @(posedge clk);
            #1 check("resp_valid_held", bus.resp_valid, 1);
            bus.resp_ready = 1'b1;
        end
        @(posedge clk); #1;
        check("idle_after_handshake", {bus.req_ready, bus.resp_valid}, 2'b10);
    endtask

    initial begin
        logic [31:0] a, b;
        logic [1:0]  s;
        int          n;
        held           = 1'b0;
        held_val       = '0;
        reset_n        = 1'b0;
        kill           = 1'b0;
        bus.req_valid  = 1'b0;
        bus.op1        = '0;
        bus.op2        = '0;
        bus.mul_sel    = 2'd0;
        bus.resp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 check("reset_state", {bus.req_ready, bus.resp_valid, bus.result}, {1'b1, 1'b0, 32'h0});
        reset_n = 1'b1;
        @(posedge clk); #1;

        do_op(32'd7, 32'd6, 2'd0, 32'h0000_002A, 0, 0);
        do_op(32'h8000_0000, 32'h8000_0000, 2'd1, 32'h4000_0000, 0, 0);
        do_op(32'h8000_0000, 32'h8000_0000, 2'd0, 32'h0000_0000, 0, 0);
        do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'd2, 32'hFFFF_FFFF, 0, 0);
        do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'd3, 32'hFFFF_FFFE, 0, 0);
        do_op(32'hFFFF_FFFD, 32'd5, 2'd1, 32'hFFFF_FFFF, 5, 0);
        do_op(32'd9, 32'd9, 2'd0, 32'h0, 0, 1);
        do_op(32'd3, 32'd4, 2'd0, 32'h0000_000C, 0, 0);
        do_op(32'd11, 32'd13, 2'd0, 32'h0, 0, 2);
        do_op(32'd0, 32'd0, 2'd3, 32'h0, 0, 0);

        // kill alongside a request in IDLE must block acceptance
        bus.op1        = 32'd5;
        bus.op2        = 32'd5;
        bus.mul_sel    = 2'd0;
        bus.req_valid  = 1'b1;
        bus.resp_ready = 1'b1;
        kill           = 1'b1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        kill          = 1'b0;
        check("kill_blocks_accept", bus.req_ready, 1);
        repeat (10) @(posedge clk);
        #1;

        do_op(32'h1234_5678, 32'h9ABC_DEF0, 2'd1, 32'h0, 0, 3);
        @(posedge clk); #1;
        do_op(32'hFFFF_FFF9, 32'd6, 2'd0, 32'hFFFF_FFD6, 0, 0);

        for (int i = 0; i < 40; i++) begin
            a = pick();
            b = pick();
            s = 2'($urandom);
            do_op(a, b, s, ref_mul(a, b, s), $urandom_range(0, 3), 0);
        end

        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(posedge clk);
            n++;
        end
        check("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
